// File: rtl/resp_pkg.sv
// Shared types and default geometry for the memory response path.
// Line/word widths here are the subsystem defaults; blocks may override.
package resp_pkg;

   localparam int RESP_LINE_W = 256;
   localparam int RESP_WORD_W = 32;

   typedef enum logic {
      RESP_IDLE = 1'b0,
      RESP_SEND = 1'b1
   } resp_state_e;

endpackage

// File: rtl/resp_word_sel.sv
// Combinational word select from a line; word k sits at line[k*WORD_W +: WORD_W].
// Zero latency, no flow control.
module resp_word_sel #(
   parameter int LINE_W = 256,
   parameter int WORD_W = 32,
   parameter int IDX_W  = $clog2(LINE_W / WORD_W)
) (
   input  logic [LINE_W-1:0] line,
   input  logic [IDX_W-1:0]  idx,
   output logic [WORD_W-1:0] word
);

   assign word = line[int'(idx) * WORD_W +: WORD_W];

endmodule

// File: rtl/resp_data_unpack.sv
// Buffers one response line and streams a wrapped or clamped burst of words.
// First word one cycle after accept; 1 word/cycle; out_rdy low stalls, next line accepted only on final-word handshake.
module resp_data_unpack
   import resp_pkg::*;
#(
   parameter int LINE_W = RESP_LINE_W,
   parameter int WORD_W = RESP_WORD_W,
   localparam int NWORDS = LINE_W / WORD_W,
   localparam int IDX_W  = $clog2(NWORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [LINE_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_start,
   input  logic [IDX_W-1:0]  in_len,
   input  logic              in_wrap,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [WORD_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              busy
);

   localparam logic [IDX_W:0]   MAX_SUM = (IDX_W + 1)'(NWORDS - 1);
   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NWORDS - 1);
   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

   resp_state_e       state_q, state_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  rem_q, rem_d;
   logic [IDX_W:0]    end_sum;
   logic              send;
   logic              accept;

   assign send     = (state_q == RESP_SEND);
   assign out_vld  = send;
   assign out_last = send & (rem_q == '0);
   assign out_idx  = ptr_q;
   assign busy     = send;

   // Only the final-word path depends on out_rdy, giving zero-bubble back-to-back bursts.
   assign in_rdy  = ~rst & (~send | (out_last & out_rdy));
   assign accept  = in_vld & in_rdy;
   assign end_sum = {1'b0, in_start} + {1'b0, in_len};

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      if (accept) begin
         state_d = RESP_SEND;
         line_d  = in_data;
         ptr_d   = in_start;
         rem_d   = (!in_wrap && (end_sum > MAX_SUM)) ? (MAX_IDX - in_start) : in_len;
      end else if (send && out_rdy) begin
         if (rem_q == '0) begin
            state_d = RESP_IDLE;
         end else begin
            ptr_d = ptr_q + ONE;
            rem_d = rem_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESP_IDLE;
         line_q  <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
      end
   end

   resp_word_sel #(
      .LINE_W (LINE_W),
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W)
   ) u_word_sel (
      .line (line_q),
      .idx  (ptr_q),
      .word (out_data)
   );

endmodule

// File: tb/tb_resp_data_unpack.sv
// Bench for resp_data_unpack: directed bursts plus random traffic against a word-list model.
module tb_resp_data_unpack;

   localparam int LINE_W = 256;
   localparam int WORD_W = 32;
   localparam int NW     = LINE_W / WORD_W;
   localparam int IW     = $clog2(NW);

   logic              clk = 1'b0;
   logic              rst;
   logic              in_vld;
   logic              in_rdy;
   logic [LINE_W-1:0] in_data;
   logic [IW-1:0]     in_start;
   logic [IW-1:0]     in_len;
   logic              in_wrap;
   logic              out_vld;
   logic              out_rdy;
   logic [WORD_W-1:0] out_data;
   logic [IW-1:0]     out_idx;
   logic              out_last;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   // Expected words still to be emitted, in order.
   int          q_idx[$];
   logic [31:0] q_dat[$];
   bit          q_last[$];
   bit          last_acc;
   bit          rst_prev = 1'b0;

   always #5 clk = ~clk;

   resp_data_unpack u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .in_start (in_start),
      .in_len   (in_len),
      .in_wrap  (in_wrap),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_idx  (out_idx),
      .out_last (out_last),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_burst(input logic [LINE_W-1:0] line, input int start, input int len, input bit wrap);
      int n;
      n = len + 1;
      if (!wrap && (start + n > NW)) n = NW - start;
      for (int k = 0; k < n; k++) begin
         int ix;
         ix = (start + k) % NW;
         q_idx.push_back(ix);
         q_dat.push_back(line[ix*WORD_W +: WORD_W]);
         q_last.push_back(k == n - 1);
      end
   endtask

   // Called right after a negedge: check 1ns before the posedge, then advance the model.
   task automatic tick();
      bit exp_rdy, pend, acc, fire;
      #4;
      pend    = (q_idx.size() != 0);
      exp_rdy = !rst && (!pend || (q_idx.size() == 1 && out_rdy));
      chk("in_rdy", in_rdy, exp_rdy);
      chk("out_vld", out_vld, pend);
      chk("busy", busy, pend);
      if (rst_prev) begin
         chk("rst_data", out_data, 0);
         chk("rst_idx", out_idx, 0);
      end
      if (pend) begin
         chk("out_idx", out_idx, q_idx[0]);
         chk("out_data", out_data, q_dat[0]);
         chk("out_last", out_last, q_last[0]);
      end else begin
         chk("idle_last", out_last, 0);
      end
      fire = pend && out_rdy;
      acc  = in_vld && exp_rdy;
      if (rst) begin
         q_idx.delete(); q_dat.delete(); q_last.delete();
      end else begin
         if (fire) begin
            void'(q_idx.pop_front()); void'(q_dat.pop_front()); void'(q_last.pop_front());
         end
         if (acc) push_burst(in_data, int'(in_start), int'(in_len), in_wrap);
      end
      rst_prev = rst;
      last_acc = acc;
      @(negedge clk);
      if (acc) in_vld = 1'b0;
   endtask

   task automatic rand_line();
      for (int k = 0; k < NW; k++) in_data[k*WORD_W +: WORD_W] = $urandom;
   endtask

   task automatic present(input int start, input int len, input bit wrap);
      int t;
      rand_line();
      in_start = IW'(start);
      in_len   = IW'(len);
      in_wrap  = wrap;
      in_vld   = 1'b1;
      t = 0;
      do begin
         tick();
         t++;
      end while (!last_acc && t < 40);
      if (!last_acc) begin
         chk("accept_timeout", 0, 1);
         in_vld = 1'b0;
      end
   endtask

   // mode 0: out_rdy held 1; mode 1: out_rdy pattern 1,0,0,1,0,0...
   task automatic drain(input int mode);
      int i;
      i = 0;
      while (q_idx.size() != 0 && i < 80) begin
         out_rdy = (mode == 0) ? 1'b1 : (i % 3 == 0);
         tick();
         i++;
      end
      if (q_idx.size() != 0) chk("drain_timeout", 0, 1);
      out_rdy = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_data = '0; in_start = '0; in_len = '0;
      in_wrap = 1'b0; out_rdy = 1'b1;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      tick();

      present(5, 7, 1'b1);  drain(0);   // wrap, full line from 5
      present(6, 4, 1'b0);  drain(0);   // clamp to 6,7
      present(2, 7, 1'b1);  drain(1);   // stalls
      present(0, 0, 1'b1);              // back-to-back: A then B
      present(3, 1, 1'b1);  drain(0);
      present(7, 0, 1'b0);  drain(0);   // single word at end

      // Reset after two words of an 8-word burst
      present(0, 7, 1'b1);
      tick(); tick();
      rst = 1'b1; tick();
      rst = 1'b0; tick();
      present(4, 7, 1'b0);  drain(0);

      for (int c = 0; c < 600; c++) begin
         if (!in_vld && $urandom_range(0, 2) == 0) begin
            rand_line();
            in_start = IW'($urandom_range(0, NW - 1));
            in_len   = IW'($urandom_range(0, NW - 1));
            in_wrap  = $urandom_range(0, 1) == 1;
            in_vld   = 1'b1;
         end
         out_rdy = $urandom_range(0, 3) != 0;
         rst     = $urandom_range(0, 99) == 0;
         tick();
      end
      rst = 1'b0;
      in_vld = 1'b0;
      drain(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
